// File: rtl/disp_sched_pkg.sv
// disp_sched_pkg: shared widths, FSM state type and column bounds for the disparity row scheduler.
package disp_sched_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, EMIT, DONE} state_t;
  function automatic int col_w(input int img_w);
    return $clog2(img_w);
  endfunction
  function automatic int disp_w(input int max_disp);
    return $clog2(max_disp);
  endfunction
  function automatic int sad_w(input int win, input int data_size);
    return $clog2(win * win * ((1 << data_size) - 1) + 1);
  endfunction
  function automatic int half_of(input int win);
    return win / 2;
  endfunction
  localparam int HALF      = 7;
  localparam int COL_FIRST = HALF;
  localparam int COL_LAST  = 64 - 1 - HALF;
endpackage

// File: rtl/disp_min_tracker.sv
// disp_min_tracker: running arg-min of (sad, d); first update after clear loads, later ones replace only on strictly smaller sad.
// DISP_MIN_SAD_EN exposes the held minimum SAD.
module disp_min_tracker #(
  parameter int SAD_W  = 16,
  parameter int DISP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              upd_i,
  input  logic [SAD_W-1:0]  sad_i,
  input  logic [DISP_W-1:0] d_i,
`ifdef DISP_MIN_SAD_EN
  output logic [SAD_W-1:0]  min_sad_o,
`endif
  output logic [DISP_W-1:0] min_d_o
);
  logic              first_q;
  logic [SAD_W-1:0]  min_sad_q;
  logic [DISP_W-1:0] min_d_q;
  logic              take;
  assign take    = upd_i && (first_q || sad_i < min_sad_q);
  assign min_d_o = min_d_q;
`ifdef DISP_MIN_SAD_EN
  assign min_sad_o = min_sad_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q   <= 1'b1;
      min_sad_q <= '0;
      min_d_q   <= '0;
    end else if (clear_i) begin
      first_q   <= 1'b1;
      min_sad_q <= '0;
      min_d_q   <= '0;
    end else begin
      if (upd_i) first_q <= 1'b0;
      if (take) begin
        min_sad_q <= sad_i;
        min_d_q   <= d_i;
      end
    end
  end
endmodule

// File: rtl/disp_row_scheduler.sv
// disp_row_scheduler: issues (x,d) SAD requests for one row, tracks the arg-min and streams one best disparity per column.
// DISP_MIN_SAD_EN adds the disp_sad output carrying the emitted column's minimum SAD.
module disp_row_scheduler
  import disp_sched_pkg::*;
#(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 64,
  parameter int MAX_DISP  = 16,
  parameter int MAX_OUTST = 4,
  localparam int COL_W    = col_w(IMG_W),
  localparam int DISP_W   = disp_w(MAX_DISP),
  localparam int SAD_W    = sad_w(WIN, DATA_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sad_req_valid,
  input  logic              sad_req_ready,
  output logic [COL_W-1:0]  sad_req_col,
  output logic [DISP_W-1:0] sad_req_disp,
  input  logic              sad_rsp_valid,
  input  logic [SAD_W-1:0]  sad_rsp_sad,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [COL_W-1:0]  disp_col,
`ifdef DISP_MIN_SAD_EN
  output logic [SAD_W-1:0]  disp_sad,
`endif
  output logic [DISP_W-1:0] disp_out
);
  localparam int HALF_P = half_of(WIN);
  localparam int C_LAST = IMG_W - 1 - HALF_P;
  localparam int OST_W  = $clog2(MAX_OUTST + 1);
  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, rel;
  logic [DISP_W-1:0] disp_q, disp_d, rsp_d_q, rsp_d_d, d_max;
  logic [OST_W-1:0]  outst_q, outst_d;
  logic              req_fire, rsp_ok, col_clear, last_col;
  assign rel           = col_q - COL_W'(HALF_P);
  assign d_max         = (rel >= COL_W'(MAX_DISP - 1)) ? DISP_W'(MAX_DISP - 1) : DISP_W'(rel);
  assign sad_req_valid = (state_q == ISSUE) && (outst_q != OST_W'(MAX_OUTST));
  assign req_fire      = sad_req_valid && sad_req_ready;
  assign rsp_ok        = sad_rsp_valid && (outst_q != '0);
  assign outst_d       = outst_q + OST_W'(req_fire) - OST_W'(rsp_ok);
  assign last_col      = col_q == COL_W'(C_LAST);
  assign col_clear     = (state_q == IDLE && start) || (state_q == EMIT && disp_ready);
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
  assign disp_valid    = state_q == EMIT;
  assign disp_col      = col_q;
  assign sad_req_col   = col_q;
  assign sad_req_disp  = disp_q;
  // Responses come back in request order, so the response count is the disparity being answered.
  assign rsp_d_d       = col_clear ? '0 : rsp_d_q + DISP_W'(rsp_ok);
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        col_d   = COL_W'(HALF_P);
        disp_d  = '0;
      end
      ISSUE: if (req_fire) begin
        state_d = (disp_q == d_max) ? DRAIN : ISSUE;
        disp_d  = (disp_q == d_max) ? disp_q : disp_q + 1'b1;
      end
      // Look at next-cycle occupancy so the beat appears right after the final response.
      DRAIN: state_d = (outst_d == '0) ? EMIT : DRAIN;
      EMIT: if (disp_ready) begin
        state_d = last_col ? DONE : ISSUE;
        col_d   = last_col ? col_q : col_q + 1'b1;
        disp_d  = '0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      disp_q  <= '0;
      rsp_d_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      disp_q  <= disp_d;
      rsp_d_q <= rsp_d_d;
      outst_q <= outst_d;
    end
  end
  disp_min_tracker #(.SAD_W(SAD_W), .DISP_W(DISP_W)) u_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (col_clear),
    .upd_i     (rsp_ok),
    .sad_i     (sad_rsp_sad),
    .d_i       (rsp_d_q),
`ifdef DISP_MIN_SAD_EN
    .min_sad_o (disp_sad),
`endif
    .min_d_o   (disp_out)
  );
endmodule

// File: tb/tb_disp_row_scheduler.sv
// tb_disp_row_scheduler: in-order SAD engine model with beat scoreboard for disp_row_scheduler.
module tb_disp_row_scheduler;
  logic        clk = 0, rst_n = 0, start = 0;
  logic        busy, done, sad_req_valid, sad_req_ready = 1, sad_rsp_valid = 0, disp_valid, disp_ready = 1;
  logic [5:0]  sad_req_col, disp_col;
  logic [3:0]  sad_req_disp, disp_out;
  logic [15:0] sad_rsp_sad = 0;
`ifdef DISP_MIN_SAD_EN
  logic [15:0] disp_sad;
`endif
  typedef struct {int due; logic [15:0] sad;} rsp_t;
  typedef struct {int col; int d; int sad;} beat_t;
  rsp_t  pend[$];
  beat_t sb[$];
  int vec = 0, miss = 0, cyc = 0;
  int mode = 0, lat = 3, stall_col = -1, stall_left = 0, hold_cnt = 0;
  bit tog = 0, prev_req_stall = 0, prev_disp_stall = 0;
  int done_cnt = 0, req_cnt = 0, exp_col = 7, exp_d = 0, exp_total = 0;
  logic [5:0] p_rcol, p_dcol;
  logic [3:0] p_rd, p_dout;
  always #5 clk = ~clk;
  disp_row_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .sad_req_valid(sad_req_valid), .sad_req_ready(sad_req_ready),
    .sad_req_col(sad_req_col), .sad_req_disp(sad_req_disp),
    .sad_rsp_valid(sad_rsp_valid), .sad_rsp_sad(sad_rsp_sad),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_col(disp_col),
`ifdef DISP_MIN_SAD_EN
    .disp_sad(disp_sad),
`endif
    .disp_out(disp_out)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int dmax(input int x);
    return (x - 7 > 15) ? 15 : x - 7;
  endfunction
  function automatic int sad_of(input int d);
    return (mode == 1) ? 500 : ((d > 5) ? d - 5 : 5 - d) * 100;
  endfunction
  // Engine, sink and request/beat monitors, all evaluated mid-cycle.
  always @(negedge clk) begin
    int osz;
    beat_t b;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      sad_rsp_valid = 0;
      prev_req_stall = 0;
      prev_disp_stall = 0;
    end else begin
      if (prev_req_stall) begin
        chk("req_hold_valid", sad_req_valid, 1);
        chk("req_hold_col", sad_req_col, p_rcol);
        chk("req_hold_disp", sad_req_disp, p_rd);
      end
      if (prev_disp_stall) begin
        chk("beat_hold_valid", disp_valid, 1);
        chk("beat_hold_col", disp_col, p_dcol);
        chk("beat_hold_out", disp_out, p_dout);
      end
      osz = pend.size();
      chk("outstanding_max", osz <= 4, 1);
      if (osz == 4) chk("req_blocked_full", sad_req_valid, 0);
      if (disp_valid) chk("no_req_in_emit", sad_req_valid, 0);
      sad_req_ready = tog ? cyc[0] : 1'b1;
      disp_ready = !(disp_valid && disp_col == stall_col && stall_left > 0);
      if (!disp_ready) stall_left--;
      if (disp_valid && disp_col == stall_col) hold_cnt++;
      if (sad_req_valid && sad_req_ready) begin
        chk("req_col", sad_req_col, exp_col);
        chk("req_disp", sad_req_disp, exp_d);
        pend.push_back('{cyc + lat, 16'(sad_of(int'(sad_req_disp)))});
        req_cnt++;
        if (exp_d == dmax(exp_col)) begin
          exp_col++;
          exp_d = 0;
        end else exp_d++;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        sad_rsp_valid = 1;
        sad_rsp_sad = pend[0].sad;
        void'(pend.pop_front());
      end else begin
        sad_rsp_valid = 0;
        sad_rsp_sad = 16'($urandom);
      end
      if (disp_valid && disp_ready) begin
        chk("beat_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          b = sb.pop_front();
          chk("beat_col", disp_col, b.col);
          chk("beat_disp", disp_out, b.d);
`ifdef DISP_MIN_SAD_EN
          chk("beat_sad", disp_sad, b.sad);
`endif
        end
      end
      if (done) done_cnt++;
      prev_req_stall = sad_req_valid && !sad_req_ready;
      p_rcol = sad_req_col;
      p_rd = sad_req_disp;
      prev_disp_stall = disp_valid && !disp_ready;
      p_dcol = disp_col;
      p_dout = disp_out;
    end
  end
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req_valid"}, sad_req_valid, 0);
    chk({tag, "_req_col"}, sad_req_col, 0);
    chk({tag, "_req_disp"}, sad_req_disp, 0);
    chk({tag, "_disp_valid"}, disp_valid, 0);
    chk({tag, "_disp_col"}, disp_col, 0);
    chk({tag, "_disp_out"}, disp_out, 0);
`ifdef DISP_MIN_SAD_EN
    chk({tag, "_disp_sad"}, disp_sad, 0);
`endif
  endtask
  task automatic begin_row(input int m, input int l, input bit t, input int sc);
    int d;
    mode = m; lat = l; tog = t; stall_col = sc; stall_left = 10; hold_cnt = 0;
    done_cnt = 0; req_cnt = 0; exp_col = 7; exp_d = 0;
    for (int x = 7; x <= 56; x++) begin
      d = (m == 1) ? 0 : ((x - 7 < 5) ? x - 7 : 5);
      sb.push_back('{x, d, sad_of(d)});
    end
    start = 1;
    @(posedge clk); #2;
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("req_after_start", sad_req_valid, 1);
  endtask
  task automatic finish_row(input string tag);
    for (int i = 0; i < 30000 && done_cnt == 0; i++) begin
      @(posedge clk); #2;
    end
    chk({tag, "_done_seen"}, done_cnt > 0, 1);
    repeat (3) begin
      @(posedge clk); #2;
    end
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_beats_left"}, sb.size(), 0);
    chk({tag, "_req_total"}, req_cnt, exp_total);
    if (stall_col >= 0) chk({tag, "_stall_cycles"}, hold_cnt, 11);
  endtask
  initial begin
    bit found;
    for (int x = 7; x <= 56; x++) exp_total += (x - 6 < 16) ? x - 6 : 16;
    repeat (3) @(posedge clk);
    #2 chk_zero("reset");
    rst_n = 1;
    @(posedge clk); #2;
    chk_zero("idle");
    begin_row(0, 3, 0, -1);
    finish_row("row_basic");
    begin_row(1, 3, 0, -1);
    finish_row("row_ties");
    begin_row(0, 3, 0, 30);
    finish_row("row_stall");
    begin_row(0, 6, 1, -1);
    finish_row("row_toggle");
    begin_row(0, 3, 0, -1);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #2;
      found = sad_req_valid && sad_req_col == 12;
    end
    chk("reach_col12", found, 1);
    rst_n = 0;
    #1 chk_zero("midrow_rst0");
    @(posedge clk); #2;
    chk_zero("midrow_rst1");
    @(posedge clk); #2;
    chk_zero("midrow_rst2");
    sb.delete();
    done_cnt = 0;
    rst_n = 1;
    repeat (5) begin
      @(posedge clk); #2;
    end
    chk("no_done_after_rst", done_cnt, 0);
    chk("idle_after_rst", busy, 0);
    begin_row(0, 3, 0, -1);
    repeat (20) begin
      @(posedge clk); #2;
    end
    start = 1;
    @(posedge clk); #2;
    start = 0;
    finish_row("row_restart");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
